// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared access-size constants, FSM states and default depth
package data_mem_responder_pkg;
  localparam int MEM_BYTES_DEF = 1024;
  localparam logic MEMC_BYTE = 1'b0;
  localparam logic MEMC_HALF = 1'b1;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
endpackage

// File: rtl/data_mem_responder_byte_ram.sv
// byte_ram: single-port 8-bit synchronous RAM with write-enable and registered read
module byte_ram #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  // read-before-write; the output register holds while en is low
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte/halfword load-store responder over a byte-wide RAM
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wmem,
  input  logic        req_memc,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(MEM_BYTES);
  state_t state_q, state_d;
  logic wmem_q, wmem_d, memc_q, memc_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [7:0] lo_q, lo_d, ram_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic ram_en, ram_we, err;
  assign err = ({1'b0, addr_q} + {16'd0, memc_q}) >= 17'(MEM_BYTES);
  assign ram_en = (state_q == ACC0) || (state_q == ACC1);
  assign ram_we = ram_en && wmem_q && !err;
  assign ram_addr = addr_q[AW-1:0] + AW'(state_q == ACC1);
  assign ram_wdata = (state_q == ACC1) ? wdata_q[15:8] : wdata_q[7:0];
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_err = rsp_valid && err;
  assign rsp_rdata = (!rsp_valid || err || wmem_q) ? 16'd0 :
                     (memc_q == MEMC_HALF) ? {ram_rdata, lo_q} : {{8{ram_rdata[7]}}, ram_rdata};
  byte_ram #(.DEPTH(MEM_BYTES)) u_ram (
    .clk(clk), .en(ram_en), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );
  // state and captured request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wmem_q <= 1'b0;
      memc_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      wmem_q <= wmem_d;
      memc_q <= memc_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      lo_q <= lo_d;
    end
  end
  // next-state: capture in IDLE, low byte saved while the high byte is read
  always_comb begin
    state_d = state_q;
    wmem_d = wmem_q;
    memc_d = memc_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    lo_d = lo_q;
    case (state_q)
      IDLE: if (req_valid) begin
        wmem_d = req_wmem;
        memc_d = req_memc;
        addr_d = req_addr;
        wdata_d = req_wdata;
        state_d = ACC0;
      end
      ACC0: state_d = (memc_q == MEMC_HALF) ? ACC1 : RESP;
      ACC1: begin
        lo_d = ram_rdata;
        state_d = RESP;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of loads, stores, errors, stalls and reset
module tb_data_mem_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_wmem = 1'b0, req_memc = 1'b0, rsp_ready = 1'b1;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  int tests = 0, fails = 0, cyc = 0;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wmem(req_wmem), .req_memc(req_memc), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic w, input logic m, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic er, output int lat, output int acc);
    req_valid = 1'b1; req_wmem = w; req_memc = m; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic w, input logic m, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_er,
                     input int exp_lat, output int acc);
    logic [15:0] rd;
    logic er;
    int lat;
    xact(w, m, a, d, rd, er, lat, acc);
    check({tag, ".rdata"}, 32'(rd), 32'(exp_rd));
    check({tag, ".err"}, 32'(er), 32'(exp_er));
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int acc, prev;
    logic [7:0] sdat [4];
    logic [15:0] sexp [4];
    sdat = '{8'h7F, 8'h80, 8'h01, 8'hC3};
    sexp = '{16'h007F, 16'hFF80, 16'h0001, 16'hFFC3};
    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", 32'(req_ready), 1);
    check("rst.rsp_valid", 32'(rsp_valid), 0);
    check("rst.rdata", 32'(rsp_rdata), 0);
    check("rst.err", 32'(rsp_err), 0);
    @(negedge clk) rst_n = 1'b1;
    // little-endian halfword store and loads with sign extension
    run("sw10", 1, 1, 16'h0010, 16'hBEEF, 16'h0000, 0, 3, acc);
    run("lw10", 0, 1, 16'h0010, 16'h0000, 16'hBEEF, 0, 3, acc);
    run("lb10", 0, 0, 16'h0010, 16'h0000, 16'hFFEF, 0, 2, acc);
    run("lb11", 0, 0, 16'h0011, 16'h0000, 16'hFFBE, 0, 2, acc);
    // byte store touches only the low byte
    run("sb21", 1, 0, 16'h0021, 16'h0077, 16'h0000, 0, 2, acc);
    run("sb20", 1, 0, 16'h0020, 16'h1234, 16'h0000, 0, 2, acc);
    run("lw20", 0, 1, 16'h0020, 16'h0000, 16'h7734, 0, 3, acc);
    // out-of-range accesses
    run("sb3fe", 1, 0, 16'h03FE, 16'h0011, 16'h0000, 0, 2, acc);
    run("sb3ff", 1, 0, 16'h03FF, 16'h0022, 16'h0000, 0, 2, acc);
    run("lw3ff", 0, 1, 16'h03FF, 16'h0000, 16'h0000, 1, 3, acc);
    run("sw3ff", 1, 1, 16'h03FF, 16'hAAAA, 16'h0000, 1, 3, acc);
    run("lb400", 0, 0, 16'h0400, 16'h0000, 16'h0000, 1, 2, acc);
    run("lb3fe", 0, 0, 16'h03FE, 16'h0000, 16'h0011, 0, 2, acc);
    run("lb3ff", 0, 0, 16'h03FF, 16'h0000, 16'h0022, 0, 2, acc);
    // response stall with a conflicting request presented outside IDLE
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wmem = 1'b0; req_memc = 1'b1; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_wmem = 1'b1; req_wdata = 16'h0000;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    check("stall.reach", 32'(rsp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("stall.valid", 32'(rsp_valid), 1);
      check("stall.rdata", 32'(rsp_rdata), 32'h0000BEEF);
      check("stall.err", 32'(rsp_err), 0);
      check("stall.req_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post.valid", 32'(rsp_valid), 0);
    check("post.rdata", 32'(rsp_rdata), 0);
    check("post.req_ready", 32'(req_ready), 1);
    run("lw10b", 0, 1, 16'h0010, 16'h0000, 16'hBEEF, 0, 3, acc);
    // reset during the high-byte write of a halfword store
    run("sb31", 1, 0, 16'h0031, 16'h0099, 16'h0000, 0, 2, acc);
    req_valid = 1'b1; req_wmem = 1'b1; req_memc = 1'b1; req_addr = 16'h0030; req_wdata = 16'hA55A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst.req_ready", 32'(req_ready), 1);
    check("arst.valid", 32'(rsp_valid), 0);
    check("arst.rdata", 32'(rsp_rdata), 0);
    check("arst.err", 32'(rsp_err), 0);
    @(negedge clk) rst_n = 1'b1;
    run("lb30", 0, 0, 16'h0030, 16'h0000, 16'h005A, 0, 2, acc);
    run("lb31", 0, 0, 16'h0031, 16'h0000, 16'hFF99, 0, 2, acc);
    // back-to-back byte stream: one accept every 3 cycles
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      run("strm.sb", 1, 0, 16'(16'h0040 + i), {8'h00, sdat[i]}, 16'h0000, 0, 2, acc);
      if (i > 0) check("strm.sb.gap", 32'(acc - prev), 3);
      prev = acc;
    end
    for (int i = 0; i < 4; i++) begin
      run("strm.lb", 0, 0, 16'(16'h0040 + i), 16'h0000, sexp[i], 0, 2, acc);
      check("strm.lb.gap", 32'(acc - prev), 3);
      prev = acc;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
